// File: rtl/adc_spi_responder.sv
// adc_spi_responder
//   Emulates an MCP3202-style 2-channel ADC on the SPI bus. The block waits
//   for a start bit, decodes {SGL/DIFF, ODD/SIGN, MSBF} and latches the
//   selected (or clamped differential) sample on the MSBF edge. It returns a
//   null bit and then the sample MSB-first, with adc_miso changing on SCLK
//   falling edges.
//
// Ports
//   clk, reset_n       system clock, synchronous active-low reset
//   adc_clk/cs/mosi    SPI pins from the master (asynchronous, synchronized here)
//   adc_miso, miso_oe  SPI data out and its drive enable
//   ch0/ch1_sample     live channel values (SAMPLE_W bits)
//   frame_done         one-clk pulse when a frame completes
//   frame_cmd          {SGL/DIFF, ODD/SIGN, MSBF} of the last completed frame
//   busy               synchronized chip select, inverted
//
// Build option
//   ADC_SPI_RESPONDER_LSBF_EN: when defined, a frame with MSBF=0 is followed
//   by an LSB-first tail (B1..B[SAMPLE_W-1]) before the frame completes.
module adc_spi_responder #(
  parameter int SAMPLE_W = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                adc_clk,
  input  logic                adc_cs,
  input  logic                adc_mosi,
  output logic                adc_miso,
  output logic                miso_oe,
  input  logic [SAMPLE_W-1:0] ch0_sample,
  input  logic [SAMPLE_W-1:0] ch1_sample,
  output logic                frame_done,
  output logic [2:0]          frame_cmd,
  output logic                busy
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SAMPLE_W - 1);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(2);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_CMD        = 3'd2;
  localparam logic [2:0] ST_NULLBIT    = 3'd3;
  localparam logic [2:0] ST_DATA       = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;
`ifdef ADC_SPI_RESPONDER_LSBF_EN
  localparam logic [2:0] ST_TAIL       = 3'd6;
`endif

  // Differential result, computed one bit wider so that a negative result
  // is visible and clamps to zero.
  function automatic logic [SAMPLE_W-1:0] sat_diff(input logic [SAMPLE_W-1:0] a,
                                                   input logic [SAMPLE_W-1:0] b);
    logic signed [SAMPLE_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[SAMPLE_W] ? '0 : d[SAMPLE_W-1:0];
  endfunction

  function automatic logic [SAMPLE_W-1:0] pick_sample(input logic sgl, input logic odd,
                                                      input logic [SAMPLE_W-1:0] c0,
                                                      input logic [SAMPLE_W-1:0] c1);
    if (sgl) return odd ? c1 : c0;
    return odd ? sat_diff(c1, c0) : sat_diff(c0, c1);
  endfunction

  logic                adc_clk_p0, adc_clk_p1, adc_clk_p2;
  logic                adc_cs_p0, adc_cs_p1, adc_cs_p2;
  logic                adc_mosi_p0, adc_mosi_p1;
  logic [2:0]          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic                sgl_q, odd_q, msbf_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                sclk_rise, sclk_fall, cs_rise, sample_load;

  // ---- stage p0/p1: synchronizers; p2: delayed copy for edge detection ----
  assign sclk_rise   = adc_clk_p1 & ~adc_clk_p2;
  assign sclk_fall   = ~adc_clk_p1 & adc_clk_p2;
  assign cs_rise     = adc_cs_p1 & ~adc_cs_p2;
  assign busy        = ~adc_cs_p1;
  // A chip-select rise in the same cycle cancels the latch along with the edge.
  assign sample_load = (state == ST_CMD) && sclk_rise && !cs_rise && (bit_cnt == CMD_LAST);

  // ---- control: synchronizers, FSM, outputs ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      adc_clk_p0  <= 1'b0;
      adc_clk_p1  <= 1'b0;
      adc_clk_p2  <= 1'b0;
      adc_cs_p0   <= 1'b1;
      adc_cs_p1   <= 1'b1;
      adc_cs_p2   <= 1'b1;
      adc_mosi_p0 <= 1'b0;
      adc_mosi_p1 <= 1'b0;
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      sgl_q       <= 1'b0;
      odd_q       <= 1'b0;
      msbf_q      <= 1'b0;
      adc_miso    <= 1'b0;
      miso_oe     <= 1'b0;
      frame_done  <= 1'b0;
      frame_cmd   <= 3'b000;
    end else begin
      adc_clk_p0  <= adc_clk;
      adc_clk_p1  <= adc_clk_p0;
      adc_clk_p2  <= adc_clk_p1;
      adc_cs_p0   <= adc_cs;
      adc_cs_p1   <= adc_cs_p0;
      adc_cs_p2   <= adc_cs_p1;
      adc_mosi_p0 <= adc_mosi;
      adc_mosi_p1 <= adc_mosi_p0;
      frame_done  <= 1'b0;

      if (cs_rise) begin
        state    <= ST_IDLE;
        adc_miso <= 1'b0;
        miso_oe  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!adc_cs_p1) state <= ST_WAIT_START;
          end
          ST_WAIT_START: begin
            if (sclk_rise && adc_mosi_p1) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              case (bit_cnt)
                CNT_W'(0): sgl_q  <= adc_mosi_p1;
                CNT_W'(1): odd_q  <= adc_mosi_p1;
                default:   msbf_q <= adc_mosi_p1;
              endcase
              if (bit_cnt == CMD_LAST) state <= ST_NULLBIT;
              else                     bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_NULLBIT: begin
            if (sclk_fall) begin
              adc_miso <= 1'b0;
              miso_oe  <= 1'b1;
              bit_cnt  <= '0;
              state    <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              if (bit_cnt == DATA_BITS) begin
`ifdef ADC_SPI_RESPONDER_LSBF_EN
                if (!msbf_q) begin
                  // B0 was the last MSB-first bit; the tail starts at B1.
                  adc_miso <= sample_q[1];
                  bit_cnt  <= CNT_W'(2);
                  state    <= ST_TAIL;
                end else begin
                  adc_miso   <= 1'b0;
                  frame_done <= 1'b1;
                  frame_cmd  <= {sgl_q, odd_q, msbf_q};
                  state      <= ST_DONE;
                end
`else
                adc_miso   <= 1'b0;
                frame_done <= 1'b1;
                frame_cmd  <= {sgl_q, odd_q, msbf_q};
                state      <= ST_DONE;
`endif
              end else begin
                adc_miso <= sample_q[LAST_IDX - bit_cnt];
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
          end
`ifdef ADC_SPI_RESPONDER_LSBF_EN
          ST_TAIL: begin
            if (sclk_fall) begin
              if (bit_cnt == DATA_BITS) begin
                adc_miso   <= 1'b0;
                frame_done <= 1'b1;
                frame_cmd  <= {sgl_q, odd_q, msbf_q};
                state      <= ST_DONE;
              end else begin
                adc_miso <= sample_q[bit_cnt];
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
          end
`endif
          ST_DONE: begin
            if (sclk_fall) adc_miso <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---- data: sample frozen on the MSBF edge ----
  always_ff @(posedge clk) begin
    if (sample_load) sample_q <= pick_sample(sgl_q, odd_q, ch0_sample, ch1_sample);
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        adc_clk;
  logic        adc_cs;
  logic        adc_mosi;
  logic        adc_miso;
  logic        miso_oe;
  logic [11:0] ch0_sample;
  logic [11:0] ch1_sample;
  logic        frame_done;
  logic [2:0]  frame_cmd;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          done_ref;
  int          change_at = -1;
  logic [11:0] ch0_new;
  logic [63:0] rx;

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done) done_cnt <= done_cnt + 1;

  adc_spi_responder #(.SAMPLE_W(12)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adc_clk    (adc_clk),
    .adc_cs     (adc_cs),
    .adc_mosi   (adc_mosi),
    .adc_miso   (adc_miso),
    .miso_oe    (miso_oe),
    .ch0_sample (ch0_sample),
    .ch1_sample (ch1_sample),
    .frame_done (frame_done),
    .frame_cmd  (frame_cmd),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Master view: adc_miso is sampled just before each SCLK rise and shifted
  // into rx, so the last SCLK of the frame lands in rx[0].
  task automatic spi_frame(input logic [15:0] cmd, input int ncmd, input int nsclk);
    rx     = '0;
    adc_cs = 1'b0;
    for (int k = 0; k < nsclk; k++) begin
      adc_mosi = (k < ncmd) ? cmd[ncmd-1-k] : 1'b0;
      repeat (HALF) @(negedge clk);
      rx      = {rx[62:0], adc_miso};
      adc_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k == change_at) ch0_sample = ch0_new;
      adc_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_release();
    adc_cs   = 1'b1;
    adc_mosi = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    adc_clk    = 1'b0;
    adc_cs     = 1'b1;
    adc_mosi   = 1'b0;
    ch0_sample = '0;
    ch1_sample = '0;
    ch0_new    = '0;
    repeat (4) @(negedge clk);
    check_val("rst_miso", adc_miso, 0);
    check_val("rst_oe", miso_oe, 0);
    check_val("rst_done", frame_done, 0);
    check_val("rst_cmd", frame_cmd, 0);
    check_val("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // busy latency: two clk edges after the chip-select pin falls
    adc_cs = 1'b0;
    @(negedge clk);
    check_val("busy_lat1", busy, 0);
    @(negedge clk);
    check_val("busy_lat2", busy, 1);
    adc_cs = 1'b1;
    repeat (6) @(negedge clk);

    // single-ended ch0
    ch0_sample = 12'hA5C;
    ch1_sample = 12'h3C3;
    done_ref   = done_cnt;
    spi_frame(16'b1101, 4, 17);
    check_val("se0_null", rx[12], 0);
    check_val("se0_data", rx[11:0], 12'hA5C);
    check_val("se0_oe", miso_oe, 1);
    check_val("se0_miso_done", adc_miso, 0);
    check_val("se0_pulse", done_cnt - done_ref, 1);
    check_val("se0_cmd", frame_cmd, 3'b101);
    cs_release();
    check_val("se0_oe_off", miso_oe, 0);
    check_val("se0_busy_off", busy, 0);
    repeat (4) @(negedge clk);

    // leading zeros, ch1
    ch1_sample = 12'h001;
    done_ref   = done_cnt;
    spi_frame(16'b0001111, 7, 20);
    check_val("lz_null", rx[12], 0);
    check_val("lz_data", rx[11:0], 12'h001);
    check_val("lz_pulse", done_cnt - done_ref, 1);
    check_val("lz_cmd", frame_cmd, 3'b111);
    cs_release();
    repeat (4) @(negedge clk);

    // reset mid-frame, then differential frames start clean
    spi_frame(16'b1101, 4, 8);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("mrst_oe", miso_oe, 0);
    check_val("mrst_busy", busy, 0);
    check_val("mrst_cmd", frame_cmd, 0);
    reset_n = 1'b1;
    cs_release();
    repeat (4) @(negedge clk);

    ch0_sample = 12'h100;
    ch1_sample = 12'h300;
    spi_frame(16'b1001, 4, 17);
    check_val("diff0_data", rx[11:0], 12'h000);
    check_val("diff0_cmd", frame_cmd, 3'b001);
    cs_release();
    repeat (4) @(negedge clk);
    spi_frame(16'b1011, 4, 17);
    check_val("diff1_data", rx[11:0], 12'h200);
    check_val("diff1_cmd", frame_cmd, 3'b011);
    cs_release();
    repeat (4) @(negedge clk);

    // abort after the 6th data bit
    ch0_sample = 12'hA5C;
    done_ref   = done_cnt;
    spi_frame(16'b1101, 4, 11);
    check_val("abort_oe_on", miso_oe, 1);
    cs_release();
    check_val("abort_oe_off", miso_oe, 0);
    check_val("abort_miso", adc_miso, 0);
    check_val("abort_nopulse", done_cnt - done_ref, 0);
    check_val("abort_cmd", frame_cmd, 3'b011);
    repeat (4) @(negedge clk);
    ch0_sample = 12'h3C3;
    spi_frame(16'b1101, 4, 17);
    check_val("post_abort_data", rx[11:0], 12'h3C3);
    cs_release();
    repeat (4) @(negedge clk);

    // ch0 changes right after the MSBF edge
    ch0_sample = 12'h0F0;
    ch0_new    = 12'hFFF;
    change_at  = 3;
    spi_frame(16'b1101, 4, 17);
    change_at  = -1;
    check_val("hold_data", rx[11:0], 12'h0F0);
    cs_release();
    repeat (4) @(negedge clk);

    // MSBF=0
    ch0_sample = 12'h801;
    done_ref   = done_cnt;
`ifdef ADC_SPI_RESPONDER_LSBF_EN
    spi_frame(16'b1100, 4, 28);
    check_val("lsbf_null", rx[23], 0);
    check_val("lsbf_data", rx[22:11], 12'h801);
    check_val("lsbf_tail", rx[10:0], 11'b000_0000_0001);
`else
    spi_frame(16'b1100, 4, 17);
    check_val("lsbf_null", rx[12], 0);
    check_val("lsbf_data", rx[11:0], 12'h801);
`endif
    check_val("lsbf_pulse", done_cnt - done_ref, 1);
    check_val("lsbf_cmd", frame_cmd, 3'b100);
    cs_release();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
